// File: rtl/fir_q_pkg.sv
// fir_q_pkg: shared state type and modular pointer helpers for the FIR window queue
package fir_q_pkg;
  typedef enum logic {IDLE, READ} state_t;
  function automatic logic [31:0] ptr_inc(input logic [31:0] p, input logic [31:0] depth);
    return (p == depth - 32'd1) ? 32'd0 : p + 32'd1;
  endfunction
  function automatic logic [31:0] ptr_sub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] depth);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[32] ? 32'(d + {1'b0, depth}) : d[31:0];
  endfunction
endpackage

// File: rtl/fir_q_ram.sv
// fir_q_ram: simple dual-port sample RAM, one write port, registered 1-cycle read port
// ports: i_we/i_waddr/i_wdata write side; i_re/i_raddr read issue, o_rdata valid the next cycle
module fir_q_ram #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fir_window_queue.sv
// fir_window_queue: multi-channel circular sample queue replaying the last WINDOW samples per new sample
// ports: clk/rst/flush control; smpl_vld/smpl_in write side; smpl_out/out_vld/out_first/out_last framed
// replay; sequencing busy flag; overrun sticky lost-trigger flag; fill_cnt saturating history count
module fir_window_queue
  import fir_q_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DEPTH = 1536,
  parameter int WINDOW = 1021,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     smpl_vld,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  output logic [NUM_CH*DATA_W-1:0] smpl_out,
  output logic                     out_vld,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     sequencing,
  output logic                     overrun,
  output logic [CW-1:0]            fill_cnt
);
  localparam int PW = $clog2(DEPTH);
  if (DEPTH < WINDOW + 2) begin : g_bad_depth
    $error("fir_window_queue: DEPTH must be at least WINDOW+2");
  end
  state_t r_state, w_state_nxt;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_win_start;
  logic [CW-1:0] r_fill, r_rd_cnt;
  logic r_pending, r_overrun, r_vld, r_first, r_last;
  logic w_trig, w_issue, w_last_issue, w_reload, w_start;
  logic [NUM_CH*DATA_W-1:0] w_rdata;
  assign w_trig = smpl_vld && (r_fill >= CW'(WINDOW - 1));
  assign w_issue = (r_state == READ);
  assign w_last_issue = w_issue && (r_rd_cnt == CW'(WINDOW - 1));
  assign w_reload = w_last_issue && (r_pending || w_trig);
  assign w_start = ((r_state == IDLE) && w_trig) || w_reload;
  // A trigger's window ends on the sample being written now; a pending burst ends on the last one written.
  assign w_win_start = PW'(ptr_sub(32'(r_wr_ptr) + 32'(smpl_vld), 32'(WINDOW), 32'(DEPTH)));
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = w_trig ? READ : IDLE;
    else w_state_nxt = (w_last_issue && !w_reload) ? IDLE : READ;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill <= '0;
      r_rd_cnt <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_vld <= 1'b0;
      r_first <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (smpl_vld) begin
        r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
        if (r_fill != CW'(WINDOW)) r_fill <= r_fill + CW'(1);
      end
      r_vld <= w_issue;
      r_first <= w_issue && (r_rd_cnt == '0);
      r_last <= w_last_issue;
      if (w_start) begin
        r_rd_ptr <= w_win_start;
        r_rd_cnt <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
      if (w_reload) r_pending <= 1'b0;
      else if (w_issue && w_trig) begin
        r_pending <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end
    end
  end
  fir_q_ram #(.W(NUM_CH * DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (smpl_vld),
    .i_waddr (r_wr_ptr),
    .i_wdata (smpl_in),
    .i_re    (w_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );
  assign smpl_out = r_vld ? w_rdata : '0;
  assign out_vld = r_vld;
  assign out_first = r_vld && r_first;
  assign out_last = r_vld && r_last;
  assign sequencing = w_issue || r_vld;
  assign overrun = r_overrun;
  assign fill_cnt = r_fill;
endmodule

// File: tb/tb_fir_window_queue.sv
// tb_fir_window_queue: directed checks of the window queue, small config plus the default config
module tb_fir_window_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, smpl_vld, out_vld, out_first, out_last, sequencing, overrun;
  logic [31:0] smpl_in, smpl_out;
  logic [2:0] fill_cnt;
  logic b_rst, b_flush, b_vld, b_ov, b_f, b_l, b_seq, b_ovr;
  logic [31:0] b_in, b_out;
  logic [9:0] b_fill;
  fir_window_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(8), .WINDOW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .smpl_vld(smpl_vld), .smpl_in(smpl_in),
    .smpl_out(smpl_out), .out_vld(out_vld), .out_first(out_first), .out_last(out_last),
    .sequencing(sequencing), .overrun(overrun), .fill_cnt(fill_cnt)
  );
  fir_window_queue dut_big (
    .clk(clk), .rst(b_rst), .flush(b_flush), .smpl_vld(b_vld), .smpl_in(b_in),
    .smpl_out(b_out), .out_vld(b_ov), .out_first(b_f), .out_last(b_l),
    .sequencing(b_seq), .overrun(b_ovr), .fill_cnt(b_fill)
  );
  function automatic logic [31:0] pk(input int v);
    return {16'(v + 100), 16'(v)};
  endfunction
  typedef struct { int v; int v1; bit f; bit l; int cyc; } obs_t;
  obs_t q[$];
  int cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_vld) q.push_back('{int'(smpl_out[15:0]), int'(smpl_out[31:16]), out_first, out_last, cyc});
  end
  bit b_mon = 0;
  int b_cnt = 0, b_nf = 0, b_nl = 0, b_runs = 0, b_fv = 0, b_lv = 0;
  bit b_prev = 0;
  always @(negedge clk) begin
    b_prev <= b_ov;
    if (b_mon && b_ov) begin
      b_cnt <= b_cnt + 1;
      if (!b_prev) b_runs <= b_runs + 1;
      if (b_f) begin b_nf <= b_nf + 1; b_fv <= int'(b_out[15:0]); end
      if (b_l) begin b_nl <= b_nl + 1; b_lv <= int'(b_out[15:0]); end
    end
  end
  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input bit fl, input bit v, input int val);
    @(negedge clk);
    flush = fl;
    smpl_vld = v;
    smpl_in = v ? pk(val) : '0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  task automatic exp_seq(input string nm, input int base, input int exp[$], input bit b2b);
    int n;
    n = q.size() - base;
    chk($sformatf("%s count", nm), 32'(n), 32'(exp.size()));
    if (n > exp.size()) n = exp.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s val[%0d]", nm, i), 32'(q[base+i].v), 32'(exp[i]));
      chk($sformatf("%s ch1[%0d]", nm, i), 32'(q[base+i].v1), 32'(exp[i] + 100));
      chk($sformatf("%s first[%0d]", nm, i), 32'(q[base+i].f), 32'(i % 5 == 0));
      chk($sformatf("%s last[%0d]", nm, i), 32'(q[base+i].l), 32'(i % 5 == 4));
      if (i > 0 && (b2b || i % 5 != 0))
        chk($sformatf("%s gap[%0d]", nm, i), 32'(q[base+i].cyc - q[base+i-1].cyc), 32'd1);
    end
  endtask
  typedef struct { bit vld; int v; bit ev; int eo; bit ef; bit el; bit es; int efill; } vec_t;
  vec_t tbl[11];
  initial begin
    int base;
    int exp[$];
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 2, 0, 0, 0, 0, 0, 2};
    tbl[2]  = '{1, 3, 0, 0, 0, 0, 0, 3};
    tbl[3]  = '{1, 4, 0, 0, 0, 0, 0, 4};
    tbl[4]  = '{1, 5, 0, 0, 0, 0, 1, 5};
    tbl[5]  = '{0, 0, 1, 1, 1, 0, 1, 5};
    tbl[6]  = '{0, 0, 1, 2, 0, 0, 1, 5};
    tbl[7]  = '{0, 0, 1, 3, 0, 0, 1, 5};
    tbl[8]  = '{0, 0, 1, 4, 0, 0, 1, 5};
    tbl[9]  = '{0, 0, 1, 5, 0, 1, 1, 5};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 5};
    rst = 1; flush = 0; smpl_vld = 0; smpl_in = '0;
    b_rst = 1; b_flush = 0; b_vld = 0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; b_rst = 0;
    chk("rst out_vld", 32'(out_vld), 0);
    chk("rst smpl_out", smpl_out, 0);
    chk("rst first", 32'(out_first), 0);
    chk("rst last", 32'(out_last), 0);
    chk("rst seq", 32'(sequencing), 0);
    chk("rst overrun", 32'(overrun), 0);
    chk("rst fill", 32'(fill_cnt), 0);
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].vld, tbl[i].v);
      @(posedge clk);
      #1;
      chk($sformatf("fill r%0d vld", i), 32'(out_vld), 32'(tbl[i].ev));
      chk($sformatf("fill r%0d out", i), smpl_out, tbl[i].ev ? pk(tbl[i].eo) : 32'd0);
      chk($sformatf("fill r%0d first", i), 32'(out_first), 32'(tbl[i].ef));
      chk($sformatf("fill r%0d last", i), 32'(out_last), 32'(tbl[i].el));
      chk($sformatf("fill r%0d seq", i), 32'(sequencing), 32'(tbl[i].es));
      chk($sformatf("fill r%0d cnt", i), 32'(fill_cnt), 32'(tbl[i].efill));
    end
    step(1, 0, 0);
    base = q.size();
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, k);
      idle(7);
    end
    exp = {};
    for (int k = 5; k <= 12; k++) for (int j = k - 4; j <= k; j++) exp.push_back(j);
    exp_seq("wrap", base, exp, 0);
    chk("wrap fill sat", 32'(fill_cnt), 5);
    step(1, 0, 0);
    base = q.size();
    for (int k = 1; k <= 5; k++) step(0, 1, k);
    idle(1);
    step(0, 1, 6);
    idle(14);
    exp = '{1, 2, 3, 4, 5, 2, 3, 4, 5, 6};
    exp_seq("pend", base, exp, 1);
    chk("pend overrun", 32'(overrun), 0);
    step(1, 0, 0);
    base = q.size();
    for (int k = 1; k <= 5; k++) step(0, 1, k);
    idle(1);
    step(0, 1, 6);
    idle(1);
    step(0, 1, 7);
    @(posedge clk);
    #1;
    chk("ovr set", 32'(overrun), 1);
    idle(20);
    exp = '{1, 2, 3, 4, 5, 3, 4, 5, 6, 7};
    exp_seq("ovr", base, exp, 1);
    chk("ovr sticky", 32'(overrun), 1);
    step(1, 0, 0);
    base = q.size();
    for (int k = 1; k <= 5; k++) step(0, 1, k);
    idle(2);
    step(1, 0, 0);
    @(posedge clk);
    #1;
    chk("flush vld", 32'(out_vld), 0);
    chk("flush fill", 32'(fill_cnt), 0);
    chk("flush seq", 32'(sequencing), 0);
    chk("flush ovr", 32'(overrun), 0);
    chk("flush partial", 32'(q.size() - base), 2);
    if (q.size() - base == 2) chk("flush no last", 32'(q[base+1].l), 0);
    for (int k = 21; k <= 24; k++) step(0, 1, k);
    idle(4);
    chk("flush 4 no burst", 32'(q.size() - base), 2);
    step(0, 1, 25);
    idle(8);
    exp = '{21, 22, 23, 24, 25};
    exp_seq("refill", base + 2, exp, 0);
    b_mon = 1;
    for (int v = 1; v <= 1021; v++) begin
      @(negedge clk);
      b_vld = 1;
      b_in = pk(v);
    end
    @(negedge clk);
    b_vld = 0;
    repeat (1030) @(negedge clk);
    chk("big count", 32'(b_cnt), 1021);
    chk("big runs", 32'(b_runs), 1);
    chk("big firsts", 32'(b_nf), 1);
    chk("big lasts", 32'(b_nl), 1);
    chk("big first val", 32'(b_fv), 1);
    chk("big last val", 32'(b_lv), 1021);
    chk("big fill", 32'(b_fill), 1021);
    b_vld = 1;
    b_in = pk(1022);
    @(negedge clk);
    b_vld = 0;
    repeat (5) @(negedge clk);
    chk("big mid vld", 32'(b_ov), 1);
    b_rst = 1;
    @(posedge clk);
    #1;
    b_rst = 0;
    chk("brst vld", 32'(b_ov), 0);
    chk("brst out", b_out, 0);
    chk("brst first", 32'(b_f), 0);
    chk("brst last", 32'(b_l), 0);
    chk("brst seq", 32'(b_seq), 0);
    chk("brst ovr", 32'(b_ovr), 0);
    chk("brst fill", 32'(b_fill), 0);
    repeat (3) @(negedge clk);
    chk("brst lasts", 32'(b_nl), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
